// File: rtl/gf_seq_mult.sv
// gf_seq_mult: bit-serial GF(2^m) multiplier, MSB-first Horner steps, reduced or raw carry-less product.
module gf_seq_mult #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mode,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    input  logic [DATA_WIDTH-1:0]   poly,
    output logic                    busy,
    output logic                    done,
    output logic [2*DATA_WIDTH-1:0] out
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = (W > 2) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic            mode_q, mode_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, poly_q, poly_d;
    logic [2*W-1:0]  acc_q, acc_d, out_q, out_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            accept;
    logic [W-1:0]    addend;
    logic [2*W-1:0]  raw_t, step;
    logic [W:0]      red_t;

    // b_q is shifted left each step so its MSB is always the current multiplier bit
    assign addend = b_q[W-1] ? a_q : '0;
    assign raw_t  = {acc_q[2*W-2:0], 1'b0} ^ {{W{1'b0}}, addend};
    assign red_t  = {acc_q[W-1:0], 1'b0} ^ {1'b0, addend};
    assign step   = mode_q ? raw_t : {{W{1'b0}}, red_t[W] ? red_t[W-1:0] ^ poly_q : red_t[W-1:0]};
    assign accept = start && (state_q != RUN);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        a_d     = a_q;
        b_d     = b_q;
        poly_d  = poly_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        if (accept) begin
            state_d = RUN;
            mode_d  = mode;
            a_d     = a;
            b_d     = b;
            poly_d  = poly;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            acc_d = step;
            b_d   = {b_q[W-2:0], 1'b0};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(W-1)) begin
                state_d = DONE;
                out_d   = step;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            poly_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            a_q     <= a_d;
            b_q     <= b_d;
            poly_q  <= poly_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign out  = out_q;
endmodule

// File: tb/tb_gf_seq_mult.sv
// tb_gf_seq_mult: directed and randomized checks of gf_seq_mult at W=4 and W=8 against a polynomial-arithmetic model.
module tb_gf_seq_mult;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        st4 = 1'b0, m4 = 1'b0, bz4, dn4;
    logic [3:0]  a4 = '0, b4 = '0, p4 = 4'b0011;
    logic [7:0]  o4;
    logic        st8 = 1'b0, m8 = 1'b0, bz8, dn8;
    logic [7:0]  a8 = '0, b8 = '0, p8 = 8'h1B;
    logic [15:0] o8;

    int n_cmp = 0;
    int n_err = 0;

    gf_seq_mult #(.DATA_WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .start(st4), .mode(m4), .a(a4), .b(b4), .poly(p4),
        .busy(bz4), .done(dn4), .out(o4)
    );
    gf_seq_mult #(.DATA_WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(st8), .mode(m8), .a(a8), .b(b8), .poly(p8),
        .busy(bz8), .done(dn8), .out(o8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full carry-less product, then long division by x^w + poly in the reduced case
    function automatic logic [31:0] ref_mul(input int w, input logic [15:0] x, input logic [15:0] y,
                                            input logic md, input logic [15:0] pl);
        logic [31:0] p = '0;
        logic [31:0] m = (32'd1 << w) | {16'd0, pl};
        for (int i = 0; i < w; i++) if (y[i]) p ^= {16'd0, x} << i;
        if (md) return p;
        for (int i = 2 * w - 2; i >= w; i--) if (p[i]) p ^= m << (i - w);
        return p & ((32'd1 << w) - 1);
    endfunction

    function automatic logic [1:0] bd(input int w);
        return (w == 4) ? {bz4, dn4} : {bz8, dn8};
    endfunction

    function automatic logic [31:0] ov(input int w);
        return (w == 4) ? {24'd0, o4} : {16'd0, o8};
    endfunction

    task automatic drive(input int w, input logic [15:0] x, input logic [15:0] y, input logic md, input logic s);
        if (w == 4) begin
            a4 = x[3:0]; b4 = y[3:0]; m4 = md; st4 = s;
        end else begin
            a8 = x[7:0]; b8 = y[7:0]; m8 = md; st8 = s;
        end
    endtask

    task automatic scramble(input int w);
        drive(w, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    endtask

    // n edges: the first n-1 must be busy without done, the n-th brings done and the result
    task automatic wait_done(input int w, input int n, input logic [31:0] exp, input string tag);
        for (int i = 1; i <= n; i++) begin
            tick();
            chk({tag, (i < n) ? " busy" : " done"}, {30'd0, bd(w)}, (i < n) ? 32'd2 : 32'd1);
        end
        chk({tag, " out"}, ov(w), exp);
    endtask

    task automatic op(input int w, input logic [15:0] x, input logic [15:0] y, input logic md,
                      input logic [31:0] exp, input string tag);
        drive(w, x, y, md, 1'b1);
        tick();
        scramble(w);
        wait_done(w, w, exp, tag);
        tick();
        chk({tag, " idle"}, {30'd0, bd(w)}, 32'd0);
        chk({tag, " hold"}, ov(w), exp);
    endtask

    initial begin
        tick();
        tick();
        chk("rst4 busy/done", {30'd0, bd(4)}, 32'd0);
        chk("rst4 out", ov(4), 32'd0);
        chk("rst8 busy/done", {30'd0, bd(8)}, 32'd0);
        chk("rst8 out", ov(8), 32'd0);
        rst = 1'b0;

        op(4, 12, 10, 1'b0, 32'h01, "red 12*10");
        op(4, 12, 10, 1'b1, 32'h78, "raw 12*10");
        op(4, 5, 9, 1'b1, 32'h2D, "raw 5*9");
        op(4, 15, 13, 1'b1, 32'h4B, "raw 15*13");

        // start held through RUN and DONE: second operation accepted straight from DONE
        drive(4, 5, 9, 1'b0, 1'b1);
        tick();
        drive(4, 15, 13, 1'b0, 1'b1);
        wait_done(4, 4, 32'h0B, "b2b first");
        tick();
        chk("b2b reaccept busy", {30'd0, bd(4)}, 32'd2);
        scramble(4);
        wait_done(4, 4, 32'h07, "b2b second");
        tick();
        chk("b2b idle", {30'd0, bd(4)}, 32'd0);

        // start during RUN must be ignored
        drive(4, 12, 10, 1'b0, 1'b1);
        tick();
        drive(4, 0, 0, 1'b0, 1'b0);
        tick();
        drive(4, 1, 1, 1'b0, 1'b1);
        tick();
        chk("ignore busy", {30'd0, bd(4)}, 32'd2);
        drive(4, 0, 0, 1'b0, 1'b0);
        wait_done(4, 2, 32'h01, "ignore");
        tick();
        chk("ignore single done", {30'd0, bd(4)}, 32'd0);
        tick();
        chk("ignore no rerun", {30'd0, bd(4)}, 32'd0);

        // reset in the second RUN cycle aborts the operation
        drive(4, 15, 13, 1'b0, 1'b1);
        tick();
        drive(4, 0, 0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort busy/done", {30'd0, bd(4)}, 32'd0);
        chk("abort out", ov(4), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort quiet", {30'd0, bd(4)}, 32'd0);
        end
        op(4, 3, 0, 1'b0, 32'h00, "zero b");

        op(8, 16'h57, 16'h83, 1'b0, 32'h00C1, "aes red");
        op(8, 16'h57, 16'h83, 1'b1, 32'h2B79, "aes raw");

        for (int i = 0; i < 30; i++) begin
            int          w;
            logic [15:0] x, y, pl;
            logic        md;
            w  = (i % 2 == 0) ? 4 : 8;
            x  = 16'($urandom);
            y  = 16'($urandom);
            md = 1'($urandom);
            x  = (w == 4) ? {12'd0, x[3:0]} : {8'd0, x[7:0]};
            y  = (w == 4) ? {12'd0, y[3:0]} : {8'd0, y[7:0]};
            pl = (w == 4) ? {12'd0, p4} : {8'd0, p8};
            op(w, x, y, md, ref_mul(w, x, y, md, pl), $sformatf("rand%0d w%0d", i, w));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/gf_seq_mult.md
Name: gf_seq_mult

Overview:
- Bit-serial GF(2^m) multiplier, m = DATA_WIDTH.
- Computes the carry-less product of two operands in one of two modes:
  - reduced mode: result is reduced modulo a run-time irreducible polynomial;
  - raw mode: full unreduced 2*DATA_WIDTH product.
- Successor to the combinational multiplier top: registered operands, start/done handshake, one operand bit per clock.
- Sits between the operand registers and the GF arithmetic datapath.

Parameters:
- DATA_WIDTH, 4, field degree m and operand width (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only in IDLE or DONE.
- mode  input  1  0 = reduced (mod poly), 1 = raw carry-less product; latched on accept.
- a  input  DATA_WIDTH  multiplicand; latched on accept.
- b  input  DATA_WIDTH  multiplier; latched on accept.
- poly  input  DATA_WIDTH  irreducible polynomial without its x^m term (x^4+x+1 -> 4'b0011); latched on accept.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; out valid.
- out  output  2*DATA_WIDTH  result; holds until next done.

Behaviour:
- Reset (rst=1 at posedge, any state): state=IDLE, busy=0, done=0, out=0, counter=0, internal registers=0. Reset mid-RUN aborts; no done is produced.
- States:
  - IDLE: start=1 latches a, b, mode, poly; clears acc and counter; -> RUN.
  - RUN: busy=1. One step per cycle on bit b[W-1-cnt], MSB first (Horner):
    - raw mode: acc(2W bits) = (acc<<1) ^ (bit ? a : 0).
    - reduced mode: t = (acc<<1) ^ (bit ? a : 0) over W+1 bits; acc = t[W] ? t[W-1:0]^poly : t[W-1:0].
    - cnt increments each step. After step cnt=W-1 -> DONE, out loaded from acc.
  - DONE: done=1 for exactly one cycle. start=1 here is accepted (back-to-back, -> RUN), else -> IDLE.
- Timing:
  - Latency: start sampled at edge k -> done high and out valid after edge k+W.
  - Throughput: one result per W+1 cycles with back-to-back starts.
- start while busy=1 is ignored; the in-flight operation is unaffected and inputs are not re-latched.
- Width rules:
  - raw mode: out = 2W-bit carry-less product; out[2W-1] is always 0.
  - reduced mode: out[W-1:0] = product mod (x^W + poly); out[2W-1:W] = 0.
- Operand inputs may change freely after the accept cycle.
- a=0 or b=0 gives out=0 after the full W-cycle latency; there is no early termination.
- out changes only on done-producing edges and on reset.
- poly is not checked for irreducibility. A reducible poly still yields the deterministic modular result.

Test Plan:
- W=4, poly=4'b0011, mode=0: a=12, b=10 -> out=0x01; done at edge k+4; busy high for exactly 4 cycles.
- Same setup, mode=1: a=12, b=10 -> out=0x78; a=5, b=9 -> out=0x2D; a=15, b=13 -> out=0x4B.
- mode=0, back-to-back with start held through DONE: (5,9) then (15,13) -> out=0x0B, then out=0x07; done pulses 5 cycles apart; each done is single-cycle.
- start pulsed with a=1, b=1 during RUN of (12,10, mode=0) -> ignored; result 0x01 only, one done pulse.
- rst asserted at the 2nd RUN cycle of (15,13) -> next edge busy=0, done=0, out=0; no done afterwards. A new start (a=3, b=0) -> out=0 after 4 cycles.
- W=8, poly=8'h1B (AES), mode=0: a=0x57, b=0x83 -> out=0x00C1 after 8 cycles; mode=1 with the same operands -> out=0x2B79.
